// File: rtl/exec_ctrl_pkg.sv
// Shared types for the execute-side fetch redirect control: epochs, execute
// state and the architectural word type.
package exec_ctrl_pkg;

  typedef logic [31:0] rvwordT;

  typedef enum logic [1:0] {
    EPOCH_INVALID = 2'd0,
    EPOCH_RED     = 2'd1,
    EPOCH_BLUE    = 2'd2
  } EpochT;

  typedef enum logic [1:0] {
    EX_RUNNING = 2'd0,
    EX_STALLED = 2'd1,
    EX_HALTED  = 2'd2
  } ExecuteStateT;

  // RED and BLUE alternate; anything else has no successor.
  function automatic EpochT epoch_toggle(input EpochT e);
    case (e)
      EPOCH_RED:  return EPOCH_BLUE;
      EPOCH_BLUE: return EPOCH_RED;
      default:    return EPOCH_INVALID;
    endcase
  endfunction

endpackage

// File: rtl/exec_ctrl_if.sv
// Bundle between instruction memory / execute datapath (master) and exec_ctrl
// (slave), including the redirect and state outputs that feed fetch.
interface exec_ctrl_if;
  import exec_ctrl_pkg::*;

  rvwordT       inst;
  rvwordT       inst_pc;
  EpochT        inst_epoch;
  logic         br_taken;
  rvwordT       br_target;
  logic         multi_start;
  logic         halt_req;

  logic         ex_valid;
  rvwordT       ex_inst;
  rvwordT       ex_pc;
  rvwordT       jumpPC;
  EpochT        jumpEpoch;
  ExecuteStateT executeState;
  logic [15:0]  drop_count;

  modport master (
    output inst, inst_pc, inst_epoch, br_taken, br_target, multi_start, halt_req,
    input  ex_valid, ex_inst, ex_pc, jumpPC, jumpEpoch, executeState, drop_count
  );

  modport slave (
    input  inst, inst_pc, inst_epoch, br_taken, br_target, multi_start, halt_req,
    output ex_valid, ex_inst, ex_pc, jumpPC, jumpEpoch, executeState, drop_count
  );

endinterface

// File: rtl/inst_hold_buf.sv
// One-entry {inst, pc, epoch} register that parks the response which lands
// while execute is not running. Clear takes priority over capture.
module inst_hold_buf
  import exec_ctrl_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   capture,
  input  logic   clear,
  input  rvwordT d_inst,
  input  rvwordT d_pc,
  input  EpochT  d_epoch,
  output rvwordT q_inst,
  output rvwordT q_pc,
  output EpochT  q_epoch,
  output logic   full
);

  rvwordT inst_q;
  rvwordT pc_q;
  EpochT  epoch_q;
  logic   full_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_q  <= '0;
      pc_q    <= '0;
      epoch_q <= EPOCH_INVALID;
      full_q  <= 1'b0;
    end else if (clear) begin
      full_q  <= 1'b0;
      epoch_q <= EPOCH_INVALID;
    end else if (capture) begin
      inst_q  <= d_inst;
      pc_q    <= d_pc;
      epoch_q <= d_epoch;
      full_q  <= 1'b1;
    end
  end

  // Fetch is held during a stall, so only one response can ever be in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(capture && full_q && !clear))
        else $error("inst_hold_buf: second capture while occupied");
    end
  end

  assign q_inst  = inst_q;
  assign q_pc    = pc_q;
  assign q_epoch = epoch_q;
  assign full    = full_q;

endmodule

// File: rtl/exec_ctrl.sv
// Execute-side control: epoch filtering of instruction responses, one-cycle
// branch redirect to fetch, and the running/stalled/halted execute state.
module exec_ctrl
  import exec_ctrl_pkg::*;
#(
  parameter int unsigned MULTI_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  exec_ctrl_if.slave  bus
);

  localparam int unsigned CntW = $clog2(MULTI_CYCLES + 1);

  ExecuteStateT  state_q;
  EpochT         cur_epoch_q;
  EpochT         jump_epoch_q;
  rvwordT        jump_pc_q;
  logic [CntW-1:0] stall_cnt_q;
  logic [15:0]   drop_cnt_q;

  logic   hold_full;
  rvwordT hold_inst;
  rvwordT hold_pc;
  EpochT  hold_epoch;

  logic   running;
  logic   use_hold;
  logic   ex_valid;
  logic   drop;
  logic   capture;
  logic   clear;
  rvwordT cand_inst;
  rvwordT cand_pc;
  EpochT  cand_epoch;

  always_comb begin
    running    = (state_q == EX_RUNNING);
    use_hold   = hold_full && running;
    cand_inst  = use_hold ? hold_inst  : bus.inst;
    cand_pc    = use_hold ? hold_pc    : bus.inst_pc;
    cand_epoch = use_hold ? hold_epoch : bus.inst_epoch;
    ex_valid   = !rst && running && (cand_epoch == cur_epoch_q) &&
                 (cand_epoch != EPOCH_INVALID);
    drop       = !rst && running && (cand_epoch != cur_epoch_q) &&
                 (cand_epoch != EPOCH_INVALID);
    capture    = !running && (bus.inst_epoch != EPOCH_INVALID);
    // Halted never resumes, so anything parked there is thrown away uncounted.
    clear      = use_hold || (state_q == EX_HALTED);
  end

  inst_hold_buf u_hold (
    .clk     (clk),
    .rst     (rst),
    .capture (capture),
    .clear   (clear),
    .d_inst  (bus.inst),
    .d_pc    (bus.inst_pc),
    .d_epoch (bus.inst_epoch),
    .q_inst  (hold_inst),
    .q_pc    (hold_pc),
    .q_epoch (hold_epoch),
    .full    (hold_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EX_RUNNING;
      cur_epoch_q  <= EPOCH_RED;
      jump_epoch_q <= EPOCH_INVALID;
      jump_pc_q    <= '0;
      stall_cnt_q  <= '0;
      drop_cnt_q   <= '0;
    end else begin
      jump_epoch_q <= EPOCH_INVALID;
      if (drop && (drop_cnt_q != 16'hFFFF)) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
      case (state_q)
        EX_RUNNING: begin
          if (ex_valid) begin
            if (bus.halt_req) begin
              state_q <= EX_HALTED;
            end else begin
              if (bus.br_taken) begin
                jump_pc_q    <= bus.br_target;
                jump_epoch_q <= epoch_toggle(cur_epoch_q);
                cur_epoch_q  <= epoch_toggle(cur_epoch_q);
              end
              if (bus.multi_start) begin
                state_q     <= EX_STALLED;
                stall_cnt_q <= CntW'(MULTI_CYCLES);
              end
            end
          end
        end
        EX_STALLED: begin
          stall_cnt_q <= stall_cnt_q - CntW'(1);
          // Leave on the edge where the counter hits zero.
          if (stall_cnt_q == CntW'(1)) begin
            state_q <= EX_RUNNING;
          end
        end
        EX_HALTED: state_q <= EX_HALTED;
        default:   state_q <= EX_RUNNING;
      endcase
    end
  end

  assign bus.ex_valid     = ex_valid;
  assign bus.ex_inst      = cand_inst;
  assign bus.ex_pc        = cand_pc;
  assign bus.jumpPC       = jump_pc_q;
  assign bus.jumpEpoch    = jump_epoch_q;
  assign bus.executeState = state_q;
  assign bus.drop_count   = drop_cnt_q;

endmodule

// File: tb/tb_exec_ctrl.sv
// Directed bench for exec_ctrl: expected presented instructions are queued when
// their response is driven and popped when the DUT raises ex_valid.
module tb_exec_ctrl;
  import exec_ctrl_pkg::*;

  logic clk;
  logic rst;
  exec_ctrl_if bus ();

  exec_ctrl #(.MULTI_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;
  logic [63:0] sb_q[$];

  function automatic rvwordT inst_of(input rvwordT pc);
    return pc ^ 32'hA5C3_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
  endtask

  // One clock cycle: drive after the edge, compare at the falling edge.
  task automatic step(input rvwordT pc, input EpochT ep, input bit push, input bit exp_v,
                      input bit br = 1'b0, input rvwordT tgt = '0, input bit multi = 1'b0,
                      input bit halt = 1'b0, input bit r = 1'b0);
    logic [63:0] e;
    @(posedge clk);
    #1;
    rst             = r;
    bus.inst        = inst_of(pc);
    bus.inst_pc     = pc;
    bus.inst_epoch  = ep;
    bus.br_taken    = br;
    bus.br_target   = tgt;
    bus.multi_start = multi;
    bus.halt_req    = halt;
    if (push) sb_q.push_back({inst_of(pc), pc});
    @(negedge clk);
    chk("ex_valid", 32'(bus.ex_valid), 32'(exp_v));
    if (bus.ex_valid) begin
      checks++;
      assert (sb_q.size() != 0)
        else begin
          failures++;
          $error("FAIL sb_underflow observed=ex_pc 0x%0h expected=no instruction", bus.ex_pc);
        end
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("ex_pc", bus.ex_pc, e[31:0]);
        chk("ex_inst", bus.ex_inst, e[63:32]);
      end
    end
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    rst             = 1'b1;
    bus.inst        = '0;
    bus.inst_pc     = '0;
    bus.inst_epoch  = EPOCH_INVALID;
    bus.br_taken    = 1'b0;
    bus.br_target   = '0;
    bus.multi_start = 1'b0;
    bus.halt_req    = 1'b0;

    // Reset: a current-epoch response must still be masked.
    step(32'h0, EPOCH_RED, 0, 0, 0, 0, 0, 0, 1);
    step(32'h0, EPOCH_INVALID, 0, 0, 0, 0, 0, 0, 1);
    chk("rst_state", 32'(bus.executeState), 32'(EX_RUNNING));
    chk("rst_jump_epoch", 32'(bus.jumpEpoch), 32'(EPOCH_INVALID));
    chk("rst_jump_pc", bus.jumpPC, 32'h0);
    chk("rst_drop", 32'(bus.drop_count), 32'd0);

    // Straight-line RED stream, branch at 0x8.
    step(32'h0, EPOCH_RED, 1, 1);
    chk("run_state", 32'(bus.executeState), 32'(EX_RUNNING));
    step(32'h4, EPOCH_RED, 1, 1);
    chk("run_jump_epoch", 32'(bus.jumpEpoch), 32'(EPOCH_INVALID));
    step(32'h8, EPOCH_RED, 1, 1, 1, 32'h100);
    chk("br_not_yet", 32'(bus.jumpEpoch), 32'(EPOCH_INVALID));
    step(32'hC, EPOCH_RED, 0, 0);
    chk("br_jump_epoch", 32'(bus.jumpEpoch), 32'(EPOCH_BLUE));
    chk("br_jump_pc", bus.jumpPC, 32'h100);
    step(32'h10, EPOCH_RED, 0, 0);
    chk("br_pulse_end", 32'(bus.jumpEpoch), 32'(EPOCH_INVALID));
    chk("drop_1", 32'(bus.drop_count), 32'd1);
    step(32'h100, EPOCH_BLUE, 1, 1);
    chk("drop_2", 32'(bus.drop_count), 32'd2);

    // Multi-cycle op; the response landing in the first stall cycle is held.
    step(32'h10, EPOCH_BLUE, 1, 1, 0, 0, 1);
    chk("multi_accept_state", 32'(bus.executeState), 32'(EX_RUNNING));
    step(32'h14, EPOCH_BLUE, 1, 0);
    chk("stall_1", 32'(bus.executeState), 32'(EX_STALLED));
    for (int i = 0; i < 3; i++) begin
      step(32'h0, EPOCH_INVALID, 0, 0);
      chk("stall_n", 32'(bus.executeState), 32'(EX_STALLED));
    end
    step(32'h0, EPOCH_INVALID, 0, 1);
    chk("resume_state", 32'(bus.executeState), 32'(EX_RUNNING));
    step(32'h0, EPOCH_INVALID, 0, 0);

    // Multi + branch: held RED... now stale BLUE entry dropped on resume.
    step(32'h18, EPOCH_BLUE, 1, 1, 1, 32'h200, 1);
    step(32'h1C, EPOCH_BLUE, 0, 0);
    chk("mb_state", 32'(bus.executeState), 32'(EX_STALLED));
    chk("mb_jump_epoch", 32'(bus.jumpEpoch), 32'(EPOCH_RED));
    chk("mb_jump_pc", bus.jumpPC, 32'h200);
    for (int i = 0; i < 3; i++) begin
      step(32'h0, EPOCH_INVALID, 0, 0);
      chk("mb_stall_n", 32'(bus.executeState), 32'(EX_STALLED));
      chk("mb_pulse_gone", 32'(bus.jumpEpoch), 32'(EPOCH_INVALID));
    end
    step(32'h0, EPOCH_INVALID, 0, 0);
    chk("mb_resume", 32'(bus.executeState), 32'(EX_RUNNING));
    chk("mb_drop_pre", 32'(bus.drop_count), 32'd2);
    step(32'h200, EPOCH_RED, 1, 1);
    chk("mb_drop_post", 32'(bus.drop_count), 32'd3);

    // Halt is terminal; responses while halted are neither valid nor counted.
    step(32'h20, EPOCH_RED, 1, 1, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      step(32'h24 + 32'(4 * i), (i % 2 == 0) ? EPOCH_RED : EPOCH_INVALID, 0, 0);
      chk("halted", 32'(bus.executeState), 32'(EX_HALTED));
    end
    chk("halt_drop", 32'(bus.drop_count), 32'd3);

    step(32'h0, EPOCH_INVALID, 0, 0, 0, 0, 0, 0, 1);
    step(32'h0, EPOCH_INVALID, 0, 0);
    chk("rst2_state", 32'(bus.executeState), 32'(EX_RUNNING));
    chk("rst2_drop", 32'(bus.drop_count), 32'd0);

    // Reset in the second stall cycle, with a redirect and held entry pending.
    step(32'h40, EPOCH_BLUE, 0, 0);
    step(32'h0, EPOCH_RED, 1, 1, 1, 32'h300, 1);
    chk("d_drop", 32'(bus.drop_count), 32'd1);
    step(32'h4, EPOCH_RED, 0, 0);
    chk("d_stall", 32'(bus.executeState), 32'(EX_STALLED));
    chk("d_jump_epoch", 32'(bus.jumpEpoch), 32'(EPOCH_BLUE));
    chk("d_jump_pc", bus.jumpPC, 32'h300);
    step(32'h0, EPOCH_INVALID, 0, 0, 0, 0, 0, 0, 1);
    chk("d_stall_2", 32'(bus.executeState), 32'(EX_STALLED));
    step(32'h0, EPOCH_INVALID, 0, 0);
    chk("d_rst_state", 32'(bus.executeState), 32'(EX_RUNNING));
    chk("d_rst_jump_epoch", 32'(bus.jumpEpoch), 32'(EPOCH_INVALID));
    chk("d_rst_jump_pc", bus.jumpPC, 32'h0);
    chk("d_rst_drop", 32'(bus.drop_count), 32'd0);
    step(32'h0, EPOCH_RED, 1, 1);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
